// File: rtl/tim_etr_pkg.sv
// Shared encodings and constants for the multi-channel external-trigger conditioner.
package tim_etr_pkg;

  typedef enum logic [1:0] {
    ETM_RISE = 2'd0,
    ETM_FALL = 2'd1,
    ETM_BOTH = 2'd2,
    ETM_NONE = 2'd3
  } etm_e;

  typedef enum logic [1:0] {
    CKD_DIV1  = 2'd0,
    CKD_DIV2  = 2'd1,
    CKD_DIV4  = 2'd2,
    CKD_DIV4B = 2'd3
  } ckd_e;

  localparam int unsigned FLT_W = 4;

endpackage

// File: rtl/tim_etr_ch.sv
// One trigger channel: synchroniser, polarity, optional filter (TIM_ETR_FLT_EN), edge detect
// and N+1 prescaler.
module tim_etr_ch
  import tim_etr_pkg::*;
#(
  parameter int unsigned PS_W     = 3,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_tick,
  input  logic             i_etp,
  input  logic             i_ece,
  input  logic [1:0]       i_etm,
  input  logic [PS_W-1:0]  i_etps,
  input  logic [FLT_W-1:0] i_etf,
  input  logic             i_etr,
  output logic             o_lv,
  output logic             o_ps
);

  logic [SYNC_STG-1:0] r_sync;
  logic                r_lv;
  logic                r_lv_d;
  logic [PS_W-1:0]     r_cnt;
  logic                r_ps;
  logic                w_s;
  logic                w_act;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], i_etr};
    end
  end

  assign w_s = r_sync[SYNC_STG-1] ^ i_etp;

`ifdef TIM_ETR_FLT_EN
  logic [FLT_W-1:0] r_fcnt;

  // Compare with >= so that lowering F below the running count commits on the next miss.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lv   <= 1'b0;
      r_fcnt <= '0;
    end else if (i_etf == '0) begin
      r_lv   <= w_s;
      r_fcnt <= '0;
    end else if (i_tick) begin
      if (w_s == r_lv) begin
        r_fcnt <= '0;
      end else if (({1'b0, r_fcnt} + {{FLT_W{1'b0}}, 1'b1}) >= {1'b0, i_etf}) begin
        r_lv   <= w_s;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + {{(FLT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`else
  logic w_unused_flt;
  assign w_unused_flt = ^{i_etf, i_tick};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lv <= 1'b0;
    end else begin
      r_lv <= w_s;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_lv_d <= 1'b0;
    end else begin
      r_lv_d <= r_lv;
    end
  end

  always_comb begin
    w_act = 1'b0;
    unique case (etm_e'(i_etm))
      ETM_RISE: w_act = r_lv & ~r_lv_d;
      ETM_FALL: w_act = ~r_lv & r_lv_d;
      ETM_BOTH: w_act = r_lv ^ r_lv_d;
      ETM_NONE: w_act = 1'b0;
    endcase
  end

  // >= rather than == so a reduced N never forces a full counter wrap.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else if (!i_ece) begin
      r_cnt <= '0;
      r_ps  <= 1'b0;
    end else if (w_act) begin
      if (r_cnt >= i_etps) begin
        r_cnt <= '0;
        r_ps  <= 1'b1;
      end else begin
        r_cnt <= r_cnt + {{(PS_W-1){1'b0}}, 1'b1};
        r_ps  <= 1'b0;
      end
    end else begin
      r_ps <= 1'b0;
    end
  end

  assign o_lv = r_lv;
  assign o_ps = r_ps;

endmodule

// File: rtl/tim_etr_mc.sv
// Multi-channel ETR conditioner top: shared sampling-tick divider plus one tim_etr_ch per channel.
// Filter and divider are compiled in only when TIM_ETR_FLT_EN is defined.
module tim_etr_mc
  import tim_etr_pkg::*;
#(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned PS_W     = 3,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [CH_NUM-1:0]      rw_etp_i,
  input  logic [CH_NUM-1:0]      rw_ece_i,
  input  logic [2*CH_NUM-1:0]    rw_etm_i,
  input  logic [PS_W*CH_NUM-1:0] rw_etps_i,
  input  logic [4*CH_NUM-1:0]    rw_etf_i,
  input  logic [1:0]             rw_ckd_i,
  input  logic [CH_NUM-1:0]      etr_i,
  output logic [CH_NUM-1:0]      etrf_lv_o,
  output logic [CH_NUM-1:0]      etrf_ps_o
);

  logic                    w_tick;
  logic [FLT_W*CH_NUM-1:0] w_etf;

`ifdef TIM_ETR_FLT_EN
  logic [1:0] r_div;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_div <= 2'd0;
    end else begin
      r_div <= r_div + 2'd1;
    end
  end

  always_comb begin
    w_tick = 1'b1;
    unique case (ckd_e'(rw_ckd_i))
      CKD_DIV1:            w_tick = 1'b1;
      CKD_DIV2:            w_tick = r_div[0];
      CKD_DIV4, CKD_DIV4B: w_tick = &r_div;
    endcase
  end

  assign w_etf = rw_etf_i;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{rw_etf_i, rw_ckd_i};
  assign w_tick       = 1'b1;
  assign w_etf        = '0;
`endif

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    tim_etr_ch #(
      .PS_W     (PS_W),
      .SYNC_STG (SYNC_STG)
    ) u_ch (
      .i_clk  (clk_i),
      .i_rstn (rstn_i),
      .i_tick (w_tick),
      .i_etp  (rw_etp_i[g]),
      .i_ece  (rw_ece_i[g]),
      .i_etm  (rw_etm_i[2*g +: 2]),
      .i_etps (rw_etps_i[PS_W*g +: PS_W]),
      .i_etf  (w_etf[FLT_W*g +: FLT_W]),
      .i_etr  (etr_i[g]),
      .o_lv   (etrf_lv_o[g]),
      .o_ps   (etrf_ps_o[g])
    );
  end

endmodule

// File: tb/tb_tim_etr_mc.sv
// Directed self-checking bench for tim_etr_mc (CH_NUM=2, PS_W=3, SYNC_STG=2).
module tb_tim_etr_mc;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [1:0] rw_etp_i;
  logic [1:0] rw_ece_i;
  logic [3:0] rw_etm_i;
  logic [5:0] rw_etps_i;
  logic [7:0] rw_etf_i;
  logic [1:0] rw_ckd_i;
  logic [1:0] etr_i;
  logic [1:0] etrf_lv_o;
  logic [1:0] etrf_ps_o;

  int n_checks = 0;
  int n_fail   = 0;
  int other_hits = 0;
  int np;
  int pos;

  tim_etr_mc #(
    .CH_NUM   (2),
    .PS_W     (3),
    .SYNC_STG (2)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .rw_etp_i  (rw_etp_i),
    .rw_ece_i  (rw_ece_i),
    .rw_etm_i  (rw_etm_i),
    .rw_etps_i (rw_etps_i),
    .rw_etf_i  (rw_etf_i),
    .rw_ckd_i  (rw_ckd_i),
    .etr_i     (etr_i),
    .etrf_lv_o (etrf_lv_o),
    .etrf_ps_o (etrf_ps_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sets one trigger input, runs ncyc clocks sampling 1 time unit after each edge,
  // returns the ps pulse count and the cycle index of the first pulse.
  task automatic drive(input int ch, input logic val, input int ncyc,
                       output int npulse, output int first);
    etr_i[ch] = val;
    npulse = 0;
    first  = -1;
    for (int j = 1; j <= ncyc; j++) begin
      @(posedge clk_i);
      #1;
      if (etrf_ps_o[ch]) begin
        npulse++;
        if (first < 0) first = j;
      end
      if (ch == 0 && (etrf_ps_o[1] || etrf_lv_o[1])) other_hits++;
    end
  endtask

  initial begin
    rstn_i    = 1'b0;
    etr_i     = 2'b11;
    rw_etp_i  = 2'b00;
    rw_ece_i  = 2'b11;
    rw_etm_i  = 4'b0000;
    rw_etps_i = 6'd0;
    rw_etf_i  = 8'd0;
    rw_ckd_i  = 2'd0;

    // Reset held with inputs high: outputs stay low.
    for (int j = 0; j < 4; j++) begin
      @(posedge clk_i);
      #1;
      check("rst_lv", etrf_lv_o, 0);
      check("rst_ps", etrf_ps_o, 0);
    end
    rstn_i = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk_i);
      #1;
      check("rel_lv", etrf_lv_o, (j >= 3) ? 2'b11 : 2'b00);
      check("rel_ps", etrf_ps_o, (j == 4) ? 2'b11 : 2'b00);
    end
    etr_i = 2'b00;
    repeat (6) @(posedge clk_i);
    #1;
    check("idle_lv", etrf_lv_o, 0);

    // Divide-by-4 on channel 0.
    rw_etps_i[2:0] = 3'd3;
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1'b1, 5, np, pos);
      check("div4_np", np, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) check("div4_pos", pos, 4);
      drive(0, 1'b0, 5, np, pos);
      check("div4_fall_np", np, 0);
    end

    // Both edges with inverted polarity, N=1.
    rw_ece_i[0]    = 1'b0;
    rw_etp_i[0]    = 1'b1;
    rw_etm_i[1:0]  = 2'd2;
    rw_etps_i[2:0] = 3'd1;
    drive(0, 1'b0, 6, np, pos);
    check("pol_lv_idle", etrf_lv_o[0], 1);
    rw_ece_i[0] = 1'b1;
    drive(0, 1'b1, 6, np, pos);
    check("both1_np", np, 0);
    check("both1_lv", etrf_lv_o[0], 0);
    drive(0, 1'b0, 6, np, pos);
    check("both2_np", np, 1);
    check("both2_pos", pos, 4);
    check("both2_lv", etrf_lv_o[0], 1);
    drive(0, 1'b1, 6, np, pos);
    check("both3_np", np, 0);
    drive(0, 1'b0, 6, np, pos);
    check("both4_np", np, 1);

    // Prescaler N reduced 7 -> 1 while count is 5.
    rw_ece_i[0]    = 1'b0;
    rw_etp_i[0]    = 1'b0;
    rw_etm_i[1:0]  = 2'd0;
    rw_etps_i[2:0] = 3'd7;
    drive(0, 1'b0, 6, np, pos);
    rw_ece_i[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1'b1, 5, np, pos);
      check("n7_np", np, 0);
      drive(0, 1'b0, 5, np, pos);
    end
    rw_etps_i[2:0] = 3'd1;
    drive(0, 1'b1, 5, np, pos);
    check("nred_np", np, 1);
    check("nred_pos", pos, 4);
    drive(0, 1'b0, 5, np, pos);
    drive(0, 1'b1, 5, np, pos);
    check("n1_a_np", np, 0);
    drive(0, 1'b0, 5, np, pos);
    drive(0, 1'b1, 5, np, pos);
    check("n1_b_np", np, 1);
    drive(0, 1'b0, 5, np, pos);

    // Enable dropped mid-count clears the count.
    rw_etps_i[2:0] = 3'd3;
    for (int k = 1; k <= 2; k++) begin
      drive(0, 1'b1, 5, np, pos);
      check("pre_off_np", np, 0);
      drive(0, 1'b0, 5, np, pos);
    end
    rw_ece_i[0] = 1'b0;
    drive(0, 1'b1, 5, np, pos);
    check("ece_off_np", np, 0);
    check("ece_off_lv", etrf_lv_o[0], 1);
    drive(0, 1'b0, 5, np, pos);
    rw_ece_i[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1'b1, 5, np, pos);
      check("ece_on_np", np, (k == 4) ? 1 : 0);
      drive(0, 1'b0, 5, np, pos);
    end

    // Channel isolation: ch0 toggles with N=0, ch1 static.
    rw_etps_i[2:0] = 3'd0;
    other_hits = 0;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b1, 5, np, pos);
      check("iso_np", np, 1);
      drive(0, 1'b0, 5, np, pos);
    end
    check("iso_ch1", other_hits, 0);

`ifdef TIM_ETR_FLT_EN
    // Filter F=4 sampled every other clock.
    rw_etf_i[3:0] = 4'd4;
    rw_ckd_i      = 2'd1;
    drive(0, 1'b0, 6, np, pos);
    drive(0, 1'b1, 5, np, pos);
    check("glitch_np", np, 0);
    drive(0, 1'b0, 12, np, pos);
    check("glitch_after_np", np, 0);
    check("glitch_lv", etrf_lv_o[0], 0);
    drive(0, 1'b1, 20, np, pos);
    check("flt_np", np, 1);
    check("flt_pos_ok", (pos >= 10 && pos <= 11) ? 1 : 0, 1);
    check("flt_lv", etrf_lv_o[0], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
